// File: rtl/riscv_mem_io_pkg.sv
// Shared constants for the RV32I data-bus responder: I/O register offsets
// (m_addr[4:2]) and STATUS bit positions.
package riscv_mem_io_pkg;

  localparam logic [2:0] IO_TXDATA = 3'd0;
  localparam logic [2:0] IO_RXDATA = 3'd1;
  localparam logic [2:0] IO_STATUS = 3'd2;
  localparam logic [2:0] IO_CTRL   = 3'd3;
  localparam logic [2:0] IO_TIMER  = 3'd4;

  localparam int ST_TX_EMPTY    = 0;
  localparam int ST_TX_FULL     = 1;
  localparam int ST_RX_NONEMPTY = 2;
  localparam int ST_TX_OVF      = 3;
  localparam int ST_RX_OVF      = 4;

endpackage

// File: rtl/riscv_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers. A push on full is taken only when
// a pop happens on the same edge; a pop on empty is ignored.
module riscv_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  // NOTE: state updates use <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/riscv_rv32i_mem_io.sv
// Data-bus responder for the single-cycle RV32I core: byte-lane word RAM plus
// TX/RX FIFO I/O. Define RV_MEMIO_TIMER_EN to add the free-running TIMER.
module riscv_rv32i_mem_io
  import riscv_mem_io_pkg::*;
#(
  parameter int DMEM_AW = 10,
  parameter int FIFO_AW = 2
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [31:0] m_addr,
  input  logic [31:0] d_t_mem,
  input  logic [3:0]  write,
  input  logic        read,
  input  logic        io_wrn,
  input  logic        io_rdn,
  output logic [31:0] d_f_mem,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  logic [31:0]        dmem [1 << DMEM_AW];
  logic [DMEM_AW-1:0] word_idx;
  logic [2:0]         io_reg;
  logic               io_rd, io_wr, ctrl_wr;
  logic               tx_push, tx_full, tx_empty;
  logic               rx_pop, rx_full, rx_empty;
  logic [7:0]         rx_head;
  logic               tx_ovf, rx_ovf, tx_ovf_set, rx_ovf_set;
  logic [31:0]        timer_val, status;
  logic               unused_addr_bits;

  assign word_idx         = m_addr[DMEM_AW+1:2];
  assign io_reg           = m_addr[4:2];
  assign io_rd            = ~io_rdn;
  assign io_wr            = ~io_wrn;
  assign unused_addr_bits = ^{m_addr[31:DMEM_AW+2], m_addr[1:0]};

  // Any I/O strobe claims the bus, so the RAM must not see that store.
  always_ff @(posedge clk) begin
    if (!(io_rd || io_wr)) begin
      for (int i = 0; i < 4; i++) begin
        if (write[i]) dmem[word_idx][8*i +: 8] <= d_t_mem[8*i +: 8];
      end
    end
  end

  assign tx_push  = io_wr && (io_reg == IO_TXDATA);
  assign rx_pop   = io_rd && (io_reg == IO_RXDATA);
  assign ctrl_wr  = io_wr && (io_reg == IO_CTRL);
  assign tx_valid = ~tx_empty;
  assign rx_ready = ~rx_full;

  riscv_sync_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_tx_fifo (
    .clk       (clk),
    .rst_n     (clrn),
    .push      (tx_push),
    .push_data (d_t_mem[7:0]),
    .pop       (tx_ready),
    .full      (tx_full),
    .empty     (tx_empty),
    .head      (tx_data)
  );

  riscv_sync_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_rx_fifo (
    .clk       (clk),
    .rst_n     (clrn),
    .push      (rx_valid),
    .push_data (rx_data),
    .pop       (rx_pop),
    .full      (rx_full),
    .empty     (rx_empty),
    .head      (rx_head)
  );

  // A full FIFO is never empty, so a pop request on full is always honoured.
  assign tx_ovf_set = tx_push & tx_full & ~tx_ready;
  assign rx_ovf_set = rx_valid & rx_full & ~rx_pop;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      tx_ovf <= 1'b0;
      rx_ovf <= 1'b0;
    end else begin
      if (tx_ovf_set)                 tx_ovf <= 1'b1;
      else if (ctrl_wr && d_t_mem[0]) tx_ovf <= 1'b0;
      if (rx_ovf_set)                 rx_ovf <= 1'b1;
      else if (ctrl_wr && d_t_mem[1]) rx_ovf <= 1'b0;
    end
  end

`ifdef RV_MEMIO_TIMER_EN
  logic [31:0] timer;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) timer <= '0;
    else       timer <= timer + 32'd1;
  end

  assign timer_val = timer;
`else
  assign timer_val = '0;
`endif

  // NOTE: default every always_comb output first so no path infers a latch.
  always_comb begin
    status                 = '0;
    status[ST_TX_EMPTY]    = tx_empty;
    status[ST_TX_FULL]     = tx_full;
    status[ST_RX_NONEMPTY] = ~rx_empty;
    status[ST_TX_OVF]      = tx_ovf;
    status[ST_RX_OVF]      = rx_ovf;
  end

  always_comb begin
    d_f_mem = '0;
    if (io_rd) begin
      case (io_reg)
        IO_RXDATA: if (!rx_empty) d_f_mem = {24'b0, rx_head};
        IO_STATUS: d_f_mem = status;
        IO_TIMER:  d_f_mem = timer_val;
        default:   d_f_mem = '0;
      endcase
    end else if (read) begin
      d_f_mem = dmem[word_idx];
    end
  end

endmodule
